// File: rtl/mmio_pio_bank_if.sv
// Avalon-MM slave bus bundle for the PIO bank.
//   mmo_address     word address
//   mmo_read        read strobe (data returned one cycle later)
//   mmo_write       write strobe
//   mmo_writedata   write data
//   mmo_byteenable  write byte lanes
//   mmo_readdata    registered read data
interface mmio_pio_bank_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   mmo_address;
   logic                mmo_read;
   logic                mmo_write;
   logic [DATA_W-1:0]   mmo_writedata;
   logic [DATA_W/8-1:0] mmo_byteenable;
   logic [DATA_W-1:0]   mmo_readdata;

   modport master (
      output mmo_address, mmo_read, mmo_write, mmo_writedata, mmo_byteenable,
      input  mmo_readdata
   );

   modport slave (
      input  mmo_address, mmo_read, mmo_write, mmo_writedata, mmo_byteenable,
      output mmo_readdata
   );
endinterface

// File: rtl/mmio_pio_bank.sv
// Avalon-MM PIO bank: synchronised + debounced inputs with selectable edge
// capture and masked level IRQ, plus an output register with set/clear aliases.
//   clk_clk        sole clock
//   reset_reset_n  async active-low reset
//   mmo            Avalon-MM slave bus (mmio_pio_bank_if.slave)
//   pio_in         async external inputs
//   pio_out        output register
//   irq            registered level interrupt
module mmio_pio_bank #(
   parameter int               ADDR_W  = 5,
   parameter int               DATA_W  = 32,
   parameter int               N_IN    = 5,
   parameter int               N_OUT   = 8,
   parameter int               DEB_CYC = 16,
   parameter logic [DATA_W-1:0] ID_VAL = 32'h5049_4F02
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   mmio_pio_bank_if.slave       mmo,
   input  logic [N_IN-1:0]      pio_in,
   output logic [N_OUT-1:0]     pio_out,
   output logic                 irq
);

   typedef enum logic [ADDR_W-1:0] {
      REG_DATA_IN  = ADDR_W'(0),
      REG_DATA_OUT = ADDR_W'(1),
      REG_EDGE_CAP = ADDR_W'(2),
      REG_IRQ_MASK = ADDR_W'(3),
      REG_EDGE_SEL = ADDR_W'(4),
      REG_OUT_SET  = ADDR_W'(5),
      REG_OUT_CLR  = ADDR_W'(6),
      REG_ID       = ADDR_W'(7)
   } reg_addr_e;

   logic [N_IN-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
   logic [N_IN-1:0]   deb;
   logic [N_IN-1:0]   deb_dly_q, deb_dly_d;
   logic [N_IN-1:0]   cap_q, cap_d, mask_q, mask_d, esel_q, esel_d;
   logic [N_OUT-1:0]  out_q, out_d;
   logic              irq_q, irq_d;
   logic [DATA_W-1:0] readdata_q, readdata_d;
   logic [DATA_W-1:0] be_mask, wm, rd;
   logic [N_IN-1:0]   rise, fall, hit;
   reg_addr_e         addr;
   logic              unused_bits;

   assign sync1_d = pio_in;
   assign sync2_d = sync1_q;

   // Debounce: a channel's counter runs only while sync disagrees with the
   // accepted level; the level flips after DEB_CYC consecutive disagreeing cycles.
   if (DEB_CYC > 0) begin : g_deb
      localparam int CW = $clog2(DEB_CYC + 1);
      logic [CW-1:0]   cnt_q [N_IN];
      logic [CW-1:0]   cnt_d [N_IN];
      logic [N_IN-1:0] lvl_q, lvl_d;

      always_comb begin
         lvl_d = lvl_q;
         for (int unsigned i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
               if (cnt_q[i] == CW'(DEB_CYC - 1)) lvl_d[i] = sync2_q[i];
               else                              cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            lvl_q <= '0;
            for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= '0;
         end else begin
            lvl_q <= lvl_d;
            for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
         end
      end

      assign deb = lvl_q;
   end else begin : g_nodeb
      assign deb = sync2_q;
   end

   always_comb begin
      addr = reg_addr_e'(mmo.mmo_address);
      for (int unsigned i = 0; i < DATA_W / 8; i++)
         be_mask[i*8 +: 8] = {8{mmo.mmo_byteenable[i]}};
      wm = mmo.mmo_writedata & be_mask;

      // Edge detection looks only at the debounced level history, so flipping
      // EDGE_SEL on a steady input cannot create a spurious capture.
      deb_dly_d = deb;
      rise      = deb & ~deb_dly_q;
      fall      = ~deb & deb_dly_q;
      hit       = (esel_q & fall) | (~esel_q & rise);

      out_d  = out_q;
      mask_d = mask_q;
      esel_d = esel_q;
      cap_d  = cap_q;
      if (mmo.mmo_write) begin
         case (addr)
            REG_DATA_OUT: out_d  = (out_q & ~be_mask[N_OUT-1:0]) | wm[N_OUT-1:0];
            REG_OUT_SET:  out_d  = out_q | wm[N_OUT-1:0];
            REG_OUT_CLR:  out_d  = out_q & ~wm[N_OUT-1:0];
            REG_IRQ_MASK: mask_d = (mask_q & ~be_mask[N_IN-1:0]) | wm[N_IN-1:0];
            REG_EDGE_SEL: esel_d = (esel_q & ~be_mask[N_IN-1:0]) | wm[N_IN-1:0];
            REG_EDGE_CAP: cap_d  = cap_q & ~wm[N_IN-1:0];
            default: ;
         endcase
      end
      // Applied after the W1C so a same-cycle event survives the clear.
      cap_d = cap_d | hit;

      irq_d = |(cap_q & mask_q);

      // Read mux sees pre-write register values.
      rd = '0;
      case (addr)
         REG_DATA_IN:  rd[N_IN-1:0]  = deb;
         REG_DATA_OUT: rd[N_OUT-1:0] = out_q;
         REG_EDGE_CAP: rd[N_IN-1:0]  = cap_q;
         REG_IRQ_MASK: rd[N_IN-1:0]  = mask_q;
         REG_EDGE_SEL: rd[N_IN-1:0]  = esel_q;
         REG_ID:       rd            = ID_VAL;
         default: ;
      endcase
      readdata_d = mmo.mmo_read ? rd : readdata_q;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_dly_q  <= '0;
         cap_q      <= '0;
         mask_q     <= '0;
         esel_q     <= '0;
         out_q      <= '0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_dly_q  <= deb_dly_d;
         cap_q      <= cap_d;
         mask_q     <= mask_d;
         esel_q     <= esel_d;
         out_q      <= out_d;
         irq_q      <= irq_d;
         readdata_q <= readdata_d;
      end
   end

   assign unused_bits      = ^{be_mask, wm};
   assign mmo.mmo_readdata = readdata_q;
   assign pio_out          = out_q;
   assign irq              = irq_q;

endmodule

// File: tb/tb_mmio_pio_bank.sv
module tb_mmio_pio_bank;

   logic       clk;
   logic       rst_n;
   logic [4:0] pio_in;
   logic [7:0] pio_out;
   logic       irq;

   int n_checks = 0;
   int n_fail   = 0;

   mmio_pio_bank_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   mmio_pio_bank #(
      .ADDR_W(5), .DATA_W(32), .N_IN(5), .N_OUT(8), .DEB_CYC(16),
      .ID_VAL(32'h5049_4F02)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .mmo           (bus),
      .pio_in        (pio_in),
      .pio_out       (pio_out),
      .irq           (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   typedef struct {
      bit          is_wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic [7:0]  exp_out;
   } vec_t;

   vec_t vt[$];

   task automatic add_vec(input bit w, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] er, input logic [7:0] eo);
      vec_t v;
      v.is_wr = w; v.addr = a; v.data = d; v.be = be; v.exp_rd = er; v.exp_out = eo;
      vt.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // All bus tasks start and end at a falling edge and take one cycle.
   task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.mmo_address = a; bus.mmo_writedata = d; bus.mmo_byteenable = be;
      bus.mmo_write = 1'b1;
      @(negedge clk);
      bus.mmo_write = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      bus.mmo_address = a; bus.mmo_read = 1'b1;
      @(negedge clk);
      bus.mmo_read = 1'b0;
      d = bus.mmo_readdata;
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
      return m;
   endfunction

   // Reference state for the random phase.
   logic [7:0] m_out;
   logic [4:0] m_cap, m_mask, m_esel, m_in;

   function automatic logic [31:0] model_read(input logic [4:0] a);
      case (a)
         5'd0:    return {27'd0, m_in};
         5'd1:    return {24'd0, m_out};
         5'd2:    return {27'd0, m_cap};
         5'd3:    return {27'd0, m_mask};
         5'd4:    return {27'd0, m_esel};
         5'd7:    return 32'h5049_4F02;
         default: return 32'd0;
      endcase
   endfunction

   logic [31:0] rd, d, m, exp_rd;
   logic [4:0]  a;
   logic [3:0]  be;
   logic        exp_irq;

   initial begin
      rst_n = 1'b0;
      pio_in = '0;
      bus.mmo_address = '0; bus.mmo_read = 1'b0; bus.mmo_write = 1'b0;
      bus.mmo_writedata = '0; bus.mmo_byteenable = '0;

      #3;
      check("reset_pio_out", {24'd0, pio_out}, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_readdata", bus.mmo_readdata, 32'd0);
      #20 rst_n = 1'b1;
      @(negedge clk);

      // ---------------- table-driven register/bus vectors ----------------
      add_vec(1, 5'd1, 32'h0000_00A5, 4'h1, 32'h0, 8'hA5);
      add_vec(0, 5'd1, 32'h0,         4'h0, 32'hA5, 8'hA5);
      add_vec(1, 5'd5, 32'h0000_000A, 4'hF, 32'h0, 8'hAF);
      add_vec(0, 5'd1, 32'h0,         4'h0, 32'hAF, 8'hAF);
      add_vec(1, 5'd6, 32'h0000_0081, 4'hF, 32'h0, 8'h2E);
      add_vec(0, 5'd1, 32'h0,         4'h0, 32'h2E, 8'h2E);
      add_vec(0, 5'd7, 32'h0,         4'h0, 32'h5049_4F02, 8'h2E);
      add_vec(0, 5'd9, 32'h0,         4'h0, 32'h0, 8'h2E);
      add_vec(1, 5'd0, 32'hFFFF_FFFF, 4'hF, 32'h0, 8'h2E);
      add_vec(0, 5'd0, 32'h0,         4'h0, 32'h0, 8'h2E);
      add_vec(1, 5'd1, 32'hFFFF_FFFF, 4'h0, 32'h0, 8'h2E);
      add_vec(1, 5'd1, 32'hFFFF_FFFF, 4'h2, 32'h0, 8'h2E);
      add_vec(0, 5'd1, 32'h0,         4'h0, 32'h2E, 8'h2E);
      add_vec(1, 5'd3, 32'h0000_001F, 4'hF, 32'h0, 8'h2E);
      add_vec(0, 5'd3, 32'h0,         4'h0, 32'h1F, 8'h2E);
      add_vec(1, 5'd4, 32'hFFFF_FFFF, 4'hF, 32'h0, 8'h2E);
      add_vec(0, 5'd4, 32'h0,         4'h0, 32'h1F, 8'h2E);
      add_vec(0, 5'd5, 32'h0,         4'h0, 32'h0, 8'h2E);
      add_vec(0, 5'd6, 32'h0,         4'h0, 32'h0, 8'h2E);
      add_vec(0, 5'd2, 32'h0,         4'h0, 32'h0, 8'h2E);

      foreach (vt[i]) begin
         if (vt[i].is_wr) bus_write(vt[i].addr, vt[i].data, vt[i].be);
         else begin
            bus_read(vt[i].addr, rd);
            check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
         end
         check($sformatf("vec%0d_out", i), {24'd0, pio_out}, {24'd0, vt[i].exp_out});
      end

      // ---------------- debounce ----------------
      bus_write(5'd4, 32'h02, 4'hF);
      bus_write(5'd3, 32'h00, 4'hF);
      bus_write(5'd2, 32'h1F, 4'hF);
      pio_in = 5'h01;
      repeat (10) @(negedge clk);
      pio_in = 5'h00;
      repeat (30) @(negedge clk);
      bus_read(5'd0, rd); check("glitch_data_in", rd, 32'h0);
      bus_read(5'd2, rd); check("glitch_cap", rd, 32'h0);

      // Continuous reads: readdata at falling edge k shows the level before rising edge k.
      pio_in = 5'h01;
      bus.mmo_address = 5'd0; bus.mmo_read = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == 18) check("deb_latency_before", bus.mmo_readdata, 32'h0);
         if (k == 19) check("deb_latency_after", bus.mmo_readdata, 32'h1);
      end
      bus.mmo_read = 1'b0;
      repeat (21) @(negedge clk);
      bus_read(5'd2, rd); check("step_rise_cap", rd, 32'h1);

      // ---------------- edge select / irq ----------------
      pio_in = 5'h02;   // ch0 falls (rising-only), ch1 rises (falling-only)
      repeat (25) @(negedge clk);
      bus_read(5'd2, rd); check("unselected_edges", rd, 32'h1);
      bus_write(5'd2, 32'h1F, 4'hF);
      bus_write(5'd3, 32'h1F, 4'hF);
      pio_in = 5'h01;   // rise ch0, fall ch1
      repeat (25) @(negedge clk);
      bus_read(5'd2, rd); check("edge_cap", rd, 32'h3);
      check("irq_set", {31'd0, irq}, 32'd1);
      bus_write(5'd2, 32'h01, 4'hF);
      bus_read(5'd2, rd); check("w1c_bit0", rd, 32'h2);
      check("irq_still", {31'd0, irq}, 32'd1);
      bus_write(5'd2, 32'h02, 4'hF);
      check("irq_lag", {31'd0, irq}, 32'd1);
      @(negedge clk);
      check("irq_clear", {31'd0, irq}, 32'd0);

      // ---------------- hit vs W1C collision ----------------
      pio_in = 5'h05;
      repeat (18) @(negedge clk);
      bus_write(5'd2, 32'h04, 4'hF);
      bus_read(5'd2, rd); check("collision_cap", rd, 32'h4);
      bus_write(5'd2, 32'h04, 4'hF);
      bus_read(5'd2, rd); check("w1c_after", rd, 32'h0);

      // ---------------- read+write same cycle ----------------
      bus.mmo_address = 5'd3; bus.mmo_writedata = 32'h05; bus.mmo_byteenable = 4'hF;
      bus.mmo_read = 1'b1; bus.mmo_write = 1'b1;
      @(negedge clk);
      bus.mmo_read = 1'b0; bus.mmo_write = 1'b0;
      check("rw_old_value", bus.mmo_readdata, 32'h1F);
      bus_read(5'd3, rd); check("rw_new_value", rd, 32'h05);

      // ---------------- reset mid-traffic ----------------
      pio_in = 5'h01;
      bus_write(5'd5, 32'h01, 4'hF);   // cap becomes irrelevant; make irq high via W1C-free path
      bus_write(5'd3, 32'h1F, 4'hF);
      bus_write(5'd2, 32'h1F, 4'hF);
      pio_in = 5'h00;                  // ch0 falls; select falling on ch0 to raise irq
      bus_write(5'd4, 32'h01, 4'hF);
      repeat (22) @(negedge clk);
      bus_read(5'd7, rd);
      check("pre_reset_irq", {31'd0, irq}, 32'd1);
      bus.mmo_address = 5'd7; bus.mmo_read = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("async_pio_out", {24'd0, pio_out}, 32'd0);
      check("async_irq", {31'd0, irq}, 32'd0);
      check("async_readdata", bus.mmo_readdata, 32'd0);
      @(negedge clk);
      bus.mmo_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus_read(5'd3, rd); check("post_reset_mask", rd, 32'h0);
      bus_read(5'd4, rd); check("post_reset_esel", rd, 32'h0);
      bus_read(5'd1, rd); check("post_reset_out", rd, 32'h0);

      // ---------------- random register traffic vs model ----------------
      pio_in = 5'h1F;
      repeat (25) @(negedge clk);
      m_in = 5'h1F; m_cap = 5'h1F; m_mask = 5'h0; m_esel = 5'h0; m_out = 8'h0;
      for (int it = 0; it < 300; it++) begin
         a = 5'($urandom_range(0, 9));
         exp_irq = |(m_cap & m_mask);
         if ($urandom_range(0, 1) == 1) begin
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            bus_write(a, d, be);
            m = lane_mask(be) & d;
            case (a)
               5'd1: m_out  = (m_out & ~lane_mask(be)) | m[7:0];
               5'd2: m_cap  = m_cap & ~m[4:0];
               5'd3: m_mask = (m_mask & ~lane_mask(be)) | m[4:0];
               5'd4: m_esel = (m_esel & ~lane_mask(be)) | m[4:0];
               5'd5: m_out  = m_out | m[7:0];
               5'd6: m_out  = m_out & ~m[7:0];
               default: ;
            endcase
         end else begin
            exp_rd = model_read(a);
            bus_read(a, rd);
            check("rand_rd", rd, exp_rd);
         end
         check("rand_out", {24'd0, pio_out}, {24'd0, m_out});
         check("rand_irq", {31'd0, irq}, {31'd0, exp_irq});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
